// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data memory controller.
// Access size codes, FSM states, wait-counter width, counter helper.
package dmem_pkg;

  localparam logic [2:0] MS_B  = 3'b000;
  localparam logic [2:0] MS_H  = 3'b001;
  localparam logic [2:0] MS_W  = 3'b010;
  localparam logic [2:0] MS_BU = 3'b100;
  localparam logic [2:0] MS_HU = 3'b101;

  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Saturating increment for event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: combinational fault decode, store lane steering
// and load lane select/extension for the data memory controller.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DMEM_POWER = 18
) (
  input  logic        i_we,
  input  logic [2:0]  i_memsize,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic        o_err,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic        w_b;
  logic        w_h;
  logic        w_w;
  logic        w_sext;
  logic        w_oor;
  logic        w_mis;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // BU/HU exist only as loads; as stores they fall out as illegal.
  assign w_b = (i_memsize == MS_B) ||
               (!i_we && i_memsize == MS_BU);
  assign w_h = (i_memsize == MS_H) ||
               (!i_we && i_memsize == MS_HU);
  assign w_w = (i_memsize == MS_W);

  assign w_sext = (i_memsize == MS_B) ||
                  (i_memsize == MS_H);

  // No wrap: any bit above the RAM window is a fault.
  assign w_oor = (i_addr >> (DMEM_POWER + 2)) != 32'd0;

  assign w_mis = (w_h && i_addr[0]) ||
                 (w_w && (i_addr[1:0] != 2'b00));

  assign o_err = !(w_b || w_h || w_w) ||
                 w_mis || w_oor;

  assign w_byte = i_rword[{i_addr[1:0], 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rword[31:16]
                            : i_rword[15:0];

  // Lane steering; everything zero on faults, rdata zero on stores.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'd0;
    o_rdata = 32'd0;
    if (!o_err) begin
      unique case (1'b1)
        w_b: begin
          o_be    = 4'b0001 << i_addr[1:0];
          o_wdata = {4{i_wdata[7:0]}};
          o_rdata = {{24{w_sext & w_byte[7]}}, w_byte};
        end
        w_h: begin
          o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
          o_rdata = {{16{w_sext & w_half[15]}}, w_half};
        end
        w_w: begin
          o_be    = 4'b1111;
          o_wdata = i_wdata;
          o_rdata = i_rword;
        end
        default: begin
          o_be = 4'b0000;
        end
      endcase
    end
    if (i_we) begin
      o_rdata = 32'd0;
    end else begin
      o_be = 4'b0000;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word RAM behind a valid/ready port, optional wait states.
// Optional feature macro DMEM_STATS_EN adds load/store/error counters.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DMEM_POWER  = 18,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_memsize,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  localparam int LP_DEPTH = 1 << DMEM_POWER;
  localparam int LP_WLD =
    (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [WCNT_W-1:0] LP_WLOAD =
    LP_WLD[WCNT_W-1:0];

  state_t              r_state;
  state_t              w_next;
  logic [WCNT_W-1:0]   r_cnt;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [LP_DEPTH];

  logic                w_accept;
  logic                w_wait_done;
  logic                w_access;
  logic                w_a_we;
  logic [2:0]          w_a_ms;
  logic [31:0]         w_a_addr;
  logic [31:0]         w_a_wdata;
  logic [DMEM_POWER-1:0] w_idx;
  logic [31:0]         w_rword;
  logic                w_err;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rdata;

  assign w_accept    = req_valid && req_ready;
  assign w_wait_done = (r_state == ST_WAIT) &&
                       (r_cnt == '0);

  // Without wait states the access happens at the accept edge,
  // straight from the request port; otherwise from latched fields.
  generate
    if (WAIT_STATES == 0) begin : g_direct
      assign w_a_we    = req_we;
      assign w_a_ms    = req_memsize;
      assign w_a_addr  = req_addr;
      assign w_a_wdata = req_wdata;
      assign w_access  = w_accept;
    end else begin : g_latched
      logic        r_we;
      logic [2:0]  r_ms;
      logic [31:0] r_addr;
      logic [31:0] r_wdata;

      // Capture request fields at acceptance.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_we    <= 1'b0;
          r_ms    <= 3'd0;
          r_addr  <= 32'd0;
          r_wdata <= 32'd0;
        end else if (w_accept) begin
          r_we    <= req_we;
          r_ms    <= req_memsize;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
        end
      end

      assign w_a_we    = r_we;
      assign w_a_ms    = r_ms;
      assign w_a_addr  = r_addr;
      assign w_a_wdata = r_wdata;
      assign w_access  = w_wait_done;
    end
  endgenerate

  assign w_idx   = w_a_addr[DMEM_POWER+1:2];
  assign w_rword = r_mem[w_idx];

  dmem_bytelane #(
    .DMEM_POWER (DMEM_POWER)
  ) u_lane (
    .i_we      (w_a_we),
    .i_memsize (w_a_ms),
    .i_addr    (w_a_addr),
    .i_wdata   (w_a_wdata),
    .i_rword   (w_rword),
    .o_err     (w_err),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_accept) begin
          w_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready = (r_state != ST_WAIT);
    rsp_valid = (r_state == ST_RESP);
  end

  // Wait-state countdown, reloaded on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept && (WAIT_STATES != 0)) begin
      r_cnt <= LP_WLOAD;
    end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Response data, held until the next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_rdata <= w_rdata;
      r_err   <= w_err;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // RAM byte writes; contents are not reset, writes blocked in reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_access && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
        end
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] r_loads;
  logic [31:0] r_stores;
  logic [31:0] r_errs;

  // Saturating event counters, bumped at the access edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loads  <= 32'd0;
      r_stores <= 32'd0;
      r_errs   <= 32'd0;
    end else if (w_access) begin
      if (w_err) begin
        r_errs <= sat_inc(r_errs);
      end else if (w_a_we) begin
        r_stores <= sat_inc(r_stores);
      end else begin
        r_loads <= sat_inc(r_loads);
      end
    end
  end

  assign stat_loads  = r_loads;
  assign stat_stores = r_stores;
  assign stat_errs   = r_errs;
`endif

endmodule
